// File: rtl/mux4_arbiter.sv
// ============================================================================
// mux4_arbiter : 4-source round-robin burst arbiter with registered data mux
// Rev 1.0
// ============================================================================
`default_nettype none

module mux4_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  input  logic [1:0] d,
  input  logic       out_ready,
  output logic [1:0] s,
  output logic [3:0] gnt,
  output logic [1:0] y,
  output logic       y_valid,
  output logic       busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] C_MAX_BURST = 4'(MAX_BURST);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] s_q, s_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] y_q, y_d;
  logic       y_valid_q, y_valid_d;
  logic       busy_q, busy_d;

  logic [1:0] pick;
  logic [1:0] sel_data;

  // Scan from the highest offset down so the requester nearest ptr wins.
  always_comb begin
    logic [1:0] idx;
    pick = ptr_q;
    idx  = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (req[idx]) pick = idx;
    end
  end

  always_comb begin
    sel_data = a;
    case (s_q)
      2'd0:    sel_data = a;
      2'd1:    sel_data = b;
      2'd2:    sel_data = c;
      default: sel_data = d;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    s_d       = s_q;
    gnt_d     = gnt_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          s_d     = pick;
          gnt_d   = 4'b0001 << pick;
          cnt_d   = 4'd0;
          state_d = GRANT;
          busy_d  = 1'b1;
        end
      end
      default: begin
        if (!req[s_q]) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          ptr_d   = s_q + 2'd1;
        end else if (out_ready) begin
          y_d       = sel_data;
          y_valid_d = 1'b1;
          cnt_d     = cnt_q + 4'd1;
          // The beat that completes the burst also releases the grant.
          if (cnt_q + 4'd1 == C_MAX_BURST) begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            ptr_d   = s_q + 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      cnt_q     <= 4'd0;
      s_q       <= 2'd0;
      gnt_q     <= 4'b0000;
      y_q       <= 2'd0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      gnt_q     <= gnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
    end
  end

  assign s       = s_q;
  assign gnt     = gnt_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mux4_arbiter.sv
// ============================================================================
// tb_mux4_arbiter : directed self-checking bench for mux4_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux4_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [1:0] a = 2'd0, b = 2'd0, c = 2'd0, d = 2'd0;
  logic       out_ready = 1'b0;
  logic [1:0] s;
  logic [3:0] gnt;
  logic [1:0] y;
  logic       y_valid;
  logic       busy;

  int n_total = 0;
  int n_pass  = 0;

  mux4_arbiter #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_ready (out_ready),
    .s         (s),
    .gnt       (gnt),
    .y         (y),
    .y_valid   (y_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    req       = 4'b0000;
    out_ready = 1'b0;
    rst       = 1'b1;
    #2;
    rst       = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_data [4];
    int         nbeats;

    // Reset state
    rst = 1'b1;
    #3;
    check("rst_gnt", {4'd0, gnt}, 8'h00);
    check("rst_s", {6'd0, s}, 8'h00);
    check("rst_y", {6'd0, y}, 8'h00);
    check("rst_yv", {7'd0, y_valid}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    step();
    rst = 1'b0;
    step();

    // Single requester b, full burst, dead cycle, re-grant
    b = 2'b01; req = 4'b0010; out_ready = 1'b1;
    step();
    check("b_gnt", {4'd0, gnt}, 8'h02);
    check("b_s", {6'd0, s}, 8'h01);
    check("b_busy", {7'd0, busy}, 8'h01);
    check("b_yv0", {7'd0, y_valid}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      check("b_beat_yv", {7'd0, y_valid}, 8'h01);
      check("b_beat_y", {6'd0, y}, 8'h01);
      check("b_beat_gnt", {4'd0, gnt}, (i == 3) ? 8'h00 : 8'h02);
    end
    check("b_rel_busy", {7'd0, busy}, 8'h00);
    step();
    check("b_regnt", {4'd0, gnt}, 8'h02);
    check("b_regnt_yv", {7'd0, y_valid}, 8'h00);

    // All four requesting: a, b, c, d, a with one dead cycle between bursts
    do_reset();
    a = 2'b11; b = 2'b01; c = 2'b10; d = 2'b00;
    exp_data[0] = 2'b11; exp_data[1] = 2'b01; exp_data[2] = 2'b10; exp_data[3] = 2'b00;
    req = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_gnt", {4'd0, gnt}, 8'(4'b0001 << (k % 4)));
      for (int j = 0; j < 4; j++) begin
        step();
        check("rr_yv", {7'd0, y_valid}, 8'h01);
        check("rr_y", {6'd0, y}, {6'd0, exp_data[k % 4]});
      end
      check("rr_rel", {4'd0, gnt}, 8'h00);
    end

    // Grant to c with a 3-cycle stall mid-burst
    do_reset();
    c = 2'b10; req = 4'b0100; out_ready = 1'b1;
    step();
    check("c_gnt", {4'd0, gnt}, 8'h04);
    check("c_s", {6'd0, s}, 8'h02);
    step(); check("c_yv1", {7'd0, y_valid}, 8'h01);
    step(); check("c_yv2", {7'd0, y_valid}, 8'h01);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("c_stall_yv", {7'd0, y_valid}, 8'h00);
      check("c_stall_gnt", {4'd0, gnt}, 8'h04);
    end
    check("c_stall_y", {6'd0, y}, 8'h02);
    out_ready = 1'b1;
    step();
    check("c_yv3", {7'd0, y_valid}, 8'h01);
    check("c_gnt3", {4'd0, gnt}, 8'h04);
    step();
    check("c_yv4", {7'd0, y_valid}, 8'h01);
    check("c_rel", {4'd0, gnt}, 8'h00);

    // Grant to d, req[3] dropped after 2 beats, next grant to a
    do_reset();
    d = 2'b01; req = 4'b1000; out_ready = 1'b1;
    step();
    check("d_gnt", {4'd0, gnt}, 8'h08);
    step();
    step();
    check("d_yv2", {7'd0, y_valid}, 8'h01);
    req = 4'b0011;
    step();
    check("d_drop_gnt", {4'd0, gnt}, 8'h00);
    check("d_drop_yv", {7'd0, y_valid}, 8'h00);
    check("d_drop_busy", {7'd0, busy}, 8'h00);
    step();
    check("d_next_a", {4'd0, gnt}, 8'h01);
    check("d_next_s", {6'd0, s}, 8'h00);

    // Async reset mid-burst to b, then restart from ptr 0
    do_reset();
    b = 2'b11; req = 4'b0010; out_ready = 1'b1;
    step();
    step();
    check("r_pre_yv", {7'd0, y_valid}, 8'h01);
    check("r_pre_y", {6'd0, y}, 8'h03);
    rst = 1'b1;
    #1;
    check("r_gnt", {4'd0, gnt}, 8'h00);
    check("r_y", {6'd0, y}, 8'h00);
    check("r_yv", {7'd0, y_valid}, 8'h00);
    check("r_busy", {7'd0, busy}, 8'h00);
    rst = 1'b0;
    req = 4'b0110;
    step();
    check("r_next_b", {4'd0, gnt}, 8'h02);
    check("r_next_yv", {7'd0, y_valid}, 8'h00);

    // d holds its burst while a asks; a follows after the dead cycle
    do_reset();
    a = 2'b10; d = 2'b01; req = 4'b1000; out_ready = 1'b1;
    step();
    check("dd_gnt", {4'd0, gnt}, 8'h08);
    req = 4'b1001;
    nbeats = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (y_valid) nbeats++;
      check("dd_hold", {4'd0, gnt}, (i == 3) ? 8'h00 : 8'h08);
    end
    check("dd_beats", 8'(nbeats), 8'h04);
    step();
    check("dd_next_a", {4'd0, gnt}, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux4_arbiter.md
MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 4, giving the maximum beats per grant (range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 4 bits: request from sources a(bit0), b(bit1), c(bit2), d(bit3).
REQ-005 The block SHALL have ports a, b, c, d, inputs, 2 bits each: source data.
REQ-006 The block SHALL have port out_ready, input, 1 bit: the sink accepts a beat this cycle.
REQ-007 The block SHALL have port s, output, 2 bits: the registered select of the granted source (0=a .. 3=d).
REQ-008 The block SHALL have port gnt, output, 4 bits: one-hot grant, all-zero when no source is granted.
REQ-009 The block SHALL have port y, output, 2 bits: the registered output data.
REQ-010 The block SHALL have port y_valid, output, 1 bit: y holds a beat transferred on the previous edge.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in GRANT.

Function
REQ-012 The block SHALL implement states IDLE and GRANT, plus an internal 2-bit round-robin pointer ptr and a beat counter cnt.
REQ-013 In IDLE with req!=0, the block SHALL select the first requester scanning ptr, ptr+1, ... (mod 4), load s, set gnt[s]=1, clear cnt, and enter GRANT on the next edge.
REQ-014 In IDLE with req==0, the block SHALL hold state, gnt=0 and busy=0.
REQ-015 A beat SHALL occur in a GRANT cycle where req[s]=1 and out_ready=1: on that edge y<=selected data (a/b/c/d per s) and cnt<=cnt+1.
REQ-016 y_valid SHALL be 1 in the cycle after a beat edge and 0 otherwise; y SHALL hold its last value when no beat occurs.
REQ-017 With out_ready=0, the block SHALL stall: cnt, s and gnt unchanged, no beat.
REQ-018 The block SHALL release the grant (gnt<=0, ptr<=s+1 mod 4, state<=IDLE) on the edge where req[s]=0, or on the beat edge that makes cnt equal MAX_BURST.
REQ-019 Release SHALL always pass through one IDLE cycle before the next grant (one dead cycle between bursts).
REQ-020 Latency SHALL be: req rises in IDLE cycle t -> gnt/busy high in cycle t+1 -> first y_valid in cycle t+2 if out_ready=1 in t+1.
REQ-021 Changes to req bits other than req[s] during GRANT SHALL NOT affect the current grant.
REQ-022 gnt SHALL equal 4'b0001<<s while busy=1 and 0 otherwise; at most one gnt bit SHALL be high.
REQ-023 ptr SHALL wrap 3->0; with all four requesting continuously, grant order from reset SHALL be a, b, c, d, a, ...

Reset
REQ-024 While rst=1, regardless of clk, the block SHALL force state=IDLE, ptr=0, cnt=0, s=0, gnt=0, y=0, y_valid=0, busy=0.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no further beat; after release, arbitration SHALL restart from ptr=0.

Verification
REQ-026 The bench SHALL cover: req=0010, b=01, out_ready=1, MAX_BURST=4 -> gnt=0010, s=1 one cycle after req; y=01 with y_valid=1 for 4 cycles; one IDLE cycle; re-grant to b.
REQ-027 The bench SHALL cover: req=1111 held, out_ready=1 -> grants in order a, b, c, d, a, each of 4 beats, with one idle cycle between bursts.
REQ-028 The bench SHALL cover: grant to c with out_ready low for 3 cycles mid-burst -> y_valid=0 during the stall, cnt frozen, burst still totals 4 beats.
REQ-029 The bench SHALL cover: grant to d, req[3] dropped after 2 beats -> release on that edge, ptr=0, next grant to a when req[0]=1.
REQ-030 The bench SHALL cover: rst pulsed between clock edges during a burst to b -> gnt, y, y_valid and busy are 0 immediately; with req=0110 afterwards, the next grant goes to b.
REQ-031 The bench SHALL cover: req=1000 then req=0001 asserted during d's burst -> d completes MAX_BURST beats before a is granted.
